// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one packed 3x3xCH patch out per
// valid-padding window position (stride 1), one cycle after the qualifying accept.
module conv1_window_gen #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned CH    = 3,
    parameter int unsigned DW    = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic [CH*DW-1:0]       in_data,
    output logic                   in_ready,
    output logic                   valid,
    output logic [9*CH*DW-1:0]     output_act,
    output logic                   frame_done
);

    localparam int unsigned PW = CH * DW;
    localparam int unsigned OW = 9 * PW;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          emit;

    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] lb2 [IMG_W];
    // Two oldest window columns, indexed [dx][dy]; the third column is the incoming one.
    logic [PW-1:0] win [2][3];
    logic [PW-1:0] new_col [3];
    logic [OW-1:0] patch;

    assign accept   = in_valid && in_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        new_col[0] = lb2[col];
        new_col[1] = lb1[col];
        new_col[2] = in_data;
    end

    // Assemble the patch: channel k field, tap t = 3*dy + dx within it.
    always_comb begin
        patch = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            for (int unsigned dy = 0; dy < 3; dy++) begin
                patch[(9*k + 3*dy + 0)*DW +: DW] = win[0][dy][k*DW +: DW];
                patch[(9*k + 3*dy + 1)*DW +: DW] = win[1][dy][k*DW +: DW];
                patch[(9*k + 3*dy + 2)*DW +: DW] = new_col[dy][k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            in_ready   <= 1'b0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            output_act <= '0;
        end else begin
            in_ready   <= 1'b1;
            valid      <= emit;
            frame_done <= emit && last_col && last_row;
            if (emit) begin
                output_act <= patch;
            end
        end
    end

    // Window and line buffers hold data only; emission gating keeps stale contents hidden.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned dy = 0; dy < 3; dy++) begin
                win[0][dy] <= win[1][dy];
                win[1][dy] <= new_col[dy];
            end
            lb2[col] <= lb1[col];
            lb1[col] <= in_data;
        end
    end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: 4x4 and 8x8 instances against an image-based patch model.
module tb_conv1_window_gen;

    localparam int PW = 24;
    localparam int OW = 216;

    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    vld_i;
    logic [PW-1:0] din;
    logic          rdy  [2];
    logic          val  [2];
    logic          fd   [2];
    logic [OW-1:0] act  [2];

    int            errors = 0;
    int            checks = 0;
    int            img_w  [2] = '{4, 8};
    int            img_h  [2] = '{4, 8};
    int            mr     [2];
    int            mc     [2];
    logic [PW-1:0] img    [2][8][8];
    logic [OW-1:0] last   [2];
    logic [OW-1:0] obsq   [$];
    logic [OW-1:0] refq   [$];
    int            fd_pos;

    always #5 clk = ~clk;

    conv1_window_gen #(.IMG_W(4), .IMG_H(4), .CH(3), .DW(8)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(vld_i[0]), .in_data(din), .in_ready(rdy[0]),
        .valid(val[0]), .output_act(act[0]), .frame_done(fd[0])
    );

    conv1_window_gen #(.IMG_W(8), .IMG_H(8), .CH(3), .DW(8)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(vld_i[1]), .in_data(din), .in_ready(rdy[1]),
        .valid(val[1]), .output_act(act[1]), .frame_done(fd[1])
    );

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected patch for the window whose bottom-right pixel is (r,c).
    function automatic logic [OW-1:0] window_of(int s, int r, int c);
        logic [OW-1:0] w = '0;
        logic [PW-1:0] p;
        for (int k = 0; k < 3; k++)
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++) begin
                    p = img[s][r-2+dy][c-2+dx];
                    w[(9*k + 3*dy + dx)*8 +: 8] = p[k*8 +: 8];
                end
        return w;
    endfunction

    task automatic do_reset(input int n);
        rstn  = 1'b0;
        vld_i = 2'b11;
        din   = PW'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) begin
                chk("rst_ready", OW'(rdy[s]), OW'(0));
                chk("rst_valid", OW'(val[s]), OW'(0));
                chk("rst_done",  OW'(fd[s]),  OW'(0));
                chk("rst_act",   act[s],      OW'(0));
            end
        end
        for (int s = 0; s < 2; s++) begin
            mr[s] = 0; mc[s] = 0; last[s] = '0;
        end
        rstn  = 1'b1;
        vld_i = 2'b00;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            chk("ready_after_rst", OW'(rdy[s]), OW'(1));
            chk("idle_valid",      OW'(val[s]), OW'(0));
        end
    endtask

    // One clock of stimulus on instance s, then check its outputs against the model.
    task automatic push(input int s, input bit v, input logic [PW-1:0] d);
        bit rb;
        bit exp_v;
        bit exp_fd;
        rb       = rdy[s];
        vld_i    = 2'b00;
        vld_i[s] = v;
        din      = d;
        @(posedge clk); #1;
        exp_v  = 1'b0;
        exp_fd = 1'b0;
        if (v && rb) begin
            img[s][mr[s]][mc[s]] = d;
            if (mr[s] >= 2 && mc[s] >= 2) begin
                exp_v   = 1'b1;
                last[s] = window_of(s, mr[s], mc[s]);
                exp_fd  = (mr[s] == img_h[s]-1) && (mc[s] == img_w[s]-1);
            end
            mc[s]++;
            if (mc[s] == img_w[s]) begin
                mc[s] = 0;
                mr[s] = (mr[s] == img_h[s]-1) ? 0 : mr[s] + 1;
            end
        end
        chk("valid",      OW'(val[s]), OW'(exp_v));
        chk("frame_done", OW'(fd[s]),  OW'(exp_fd));
        chk("output_act", act[s],      last[s]);
        if (val[s] === 1'b1) obsq.push_back(act[s]);
        if (fd[s] === 1'b1) fd_pos = obsq.size();
        vld_i = 2'b00;
    endtask

    task automatic frame(input int s, input int off, input bit rnd, input bit gaps, input int npix);
        logic [PW-1:0] d;
        for (int i = 0; i < npix; i++) begin
            int r = i / img_w[s];
            int c = i % img_w[s];
            for (int k = 0; k < 3; k++) d[k*8 +: 8] = 8'(16*r + 4*c + k + off);
            if (rnd) d = PW'($urandom);
            if (gaps) while ($urandom_range(0, 2) == 0) push(s, 1'b0, PW'($urandom));
            push(s, 1'b1, d);
        end
        push(s, 1'b0, '0);
    endtask

    initial begin
        logic [OW-1:0] w;
        rstn  = 1'b0;
        vld_i = 2'b00;
        din   = '0;
        do_reset(3);

        // Single 4x4 frame with the documented pattern.
        obsq.delete(); fd_pos = 0;
        frame(0, 0, 1'b0, 1'b0, 16);
        chk("t1_count", OW'(obsq.size()), OW'(4));
        chk("t1_done_pos", OW'(fd_pos), OW'(4));
        if (obsq.size() == 4) begin
            w = obsq[0];
            chk("t1_first_tap0", OW'(w[7:0]),     OW'(0));
            chk("t1_first_tap8", OW'(w[71:64]),   OW'(40));
            chk("t1_first_ch2",  OW'(w[215:208]), OW'(42));
            w = obsq[3];
            chk("t1_last_tap8",  OW'(w[71:64]),   OW'(60));
        end
        refq = obsq;

        // Same frame with random input gaps.
        obsq.delete(); fd_pos = 0;
        frame(0, 0, 1'b0, 1'b1, 16);
        chk("t2_count", OW'(obsq.size()), OW'(4));
        chk("t2_done_pos", OW'(fd_pos), OW'(4));
        if (obsq.size() == 4 && refq.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_same_seq", obsq[i], refq[i]);

        // Back-to-back frames, second offset by +1.
        obsq.delete(); fd_pos = 0;
        frame(0, 0, 1'b0, 1'b0, 15);
        frame(0, 0, 1'b0, 1'b0, 0);
        obsq.delete();
        mr[0] = 0; mc[0] = 0;
        do_reset(1);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) begin
                logic [PW-1:0] d;
                for (int k = 0; k < 3; k++) d[k*8 +: 8] = 8'(16*(i/4) + 4*(i%4) + k + f);
                push(0, 1'b1, d);
            end
        push(0, 1'b0, '0);
        chk("t3_count", OW'(obsq.size()), OW'(8));
        if (obsq.size() == 8) begin
            w = obsq[4];
            chk("t3_f2_tap0", OW'(w[7:0]), OW'(1));
        end

        // Mid-frame reset after pixel (2,1), then a fresh frame.
        frame(0, 50, 1'b0, 1'b0, 10);
        do_reset(1);
        obsq.delete(); fd_pos = 0;
        frame(0, 100, 1'b0, 1'b0, 16);
        chk("t4_count", OW'(obsq.size()), OW'(4));
        chk("t4_done_pos", OW'(fd_pos), OW'(4));
        if (obsq.size() == 4) begin
            w = obsq[0];
            chk("t4_first_tap0", OW'(w[7:0]), OW'(100));
        end

        // Full random 8x8 frame with gaps, then another back-to-back.
        obsq.delete(); fd_pos = 0;
        frame(1, 0, 1'b1, 1'b1, 64);
        chk("t5_count", OW'(obsq.size()), OW'(36));
        chk("t5_done_pos", OW'(fd_pos), OW'(36));
        obsq.delete(); fd_pos = 0;
        frame(1, 0, 1'b1, 1'b0, 64);
        chk("t6_count", OW'(obsq.size()), OW'(36));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv1_window_gen.md
# conv1_window_gen

Streaming 3x3 window generator that feeds the first convolution layer. It accepts one pixel per handshake in raster order, with all input channels packed side by side. Two line buffers and a 3x3 shift window per channel build the patch. For every valid-padding window position (stride 1) it emits one packed 3x3xCH patch with a one-cycle valid pulse, in exactly the layout the conv layer slices into its per-channel fmaps and taps.

## Interface
Parameters:
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in pixels (>= 3)
- CH, 3, input channels per pixel
- DW, 8, bits per channel sample (signed, passed through unmodified)

Ports:
- clk  in  1  single clock
- rstn  in  1  reset; synchronous, active-low
- in_valid  in  1  pixel present on in_data
- in_data  in  CH*DW  pixel; channel k at [DW*k+DW-1 : DW*k]
- in_ready  out  1  block can accept a pixel
- valid  out  1  one-cycle pulse: output_act holds a new window
- output_act  out  9*CH*DW  packed window (216 bits at defaults)
- frame_done  out  1  one-cycle pulse, coincident with the last window of a frame

## Operation
- Accept: a pixel transfers on a rising edge where in_valid && in_ready. in_ready is 0 in reset, then 1 from the first edge after rstn=1, and stays 1. There is no output backpressure.
- Position counters: col in 0..IMG_W-1 and row in 0..IMG_H-1 advance only on accept. col wraps to 0 and row increments at col=IMG_W-1. After pixel (IMG_H-1, IMG_W-1), both counters return to 0 and the next accept starts a new frame. Frames may be back-to-back with no idle cycle.
- Line buffers: two IMG_W-deep CH*DW memories, lb1 holding row r-1 and lb2 holding row r-2, indexed by col. On accept, read lb1[col] and lb2[col] (the old values), write lb2[col] <= lb1[col] and lb1[col] <= in_data.
- Window: per channel, a 3x3 register array. On accept, shift columns left and load the new right column as (lb2[col], lb1[col], in_data) for (top, mid, bottom).
- Emit: when an accepted pixel has row>=2 and col>=2, the window covering rows row-2..row and cols col-2..col is registered to output_act and valid=1 on the next cycle. There are (IMG_W-2)*(IMG_H-2) windows per frame.
- Packing: channel k occupies [72k+71 : 72k], generalised as 9*DW per channel. Tap t = 3*dy + dx occupies [DW*t+DW-1 : DW*t] within the channel field. dy=0 is the oldest (top) row and dx=0 is the leftmost column.
- Stale data: window and line-buffer contents from a previous frame, or from before reset, are never emitted. Emission is gated by the row and col counters only.
- frame_done=1 in the same cycle as valid for the window ending at pixel (IMG_H-1, IMG_W-1).

## Timing
- Reset (rstn=0 at an edge): row=0, col=0, valid=0, frame_done=0, in_ready=0, output_act=0. Line-buffer memories are not reset.
- Reset mid-frame: the partial frame is abandoned, and the first accepted pixel after reset is treated as (0,0).
- Latency: accept at edge N gives valid and output_act updated at edge N+1, i.e. one cycle.
- When valid=0, output_act holds its last emitted value.
- Input gaps (in_valid=0) freeze all counters, windows and buffers; emission resumes seamlessly.
- Column wrap: the window shifts across rows, but emission is suppressed at col<2, so no window ever mixes columns from different rows.
- Maximum throughput is one window per cycle when in_valid is held high.

## Test plan
- Reset check: hold rstn=0 for 3 cycles with in_valid=1 -> in_ready=0, valid=0, output_act=0, and no pixel is accepted.
- Single frame, IMG_W=IMG_H=4, p(r,c) channel k = 16r+4c+k -> exactly 4 valid pulses. The first fires after pixel (2,2) with output_act[7:0]=0, [71:64]=40 and [215:208]=42. frame_done asserts only with the 4th pulse (centre p(2,2)=... last window tap 8 ch0 = 60).
- Gaps: same frame with in_valid toggled pseudo-randomly -> identical window sequence, each valid exactly 1 cycle after the qualifying accept.
- Back-to-back frames: 2 frames with the second frame's pixels offset by +1 -> 8 windows, with the second frame's first window showing tap0 ch0 = 1 and no stale first-frame data.
- Mid-frame reset: assert rstn=0 for 1 cycle after pixel (2,1), then stream a full frame -> exactly 4 windows, all from the new frame.
- Defaults 8x8, CH=3: full random frame -> 36 windows, each bit-exact against a software 3x3 patch model.
